wb_sram_port_controller: RTL
============================

// Module: wb_sram_port_controller
// PURPOSE
//   Wishbone classic slave that drives the primary RW port of the dual-port SRAM wrapper,
//   plus a pipelined valid/ready read-request port that drives its secondary R port.
//   Sits between the core bus interconnect / fetch unit and the SRAM array.
//   Owns SRAM read-latency alignment, byte masking and ack generation.
// PARAMETERS
//   BYTE_COUNT     4   bytes per word; DATA_WIDTH = 8*BYTE_COUNT
//   ADDRESS_SIZE   9   SRAM word-address width
//   READ_LATENCY   1   clock edges from SRAM select to valid read data (1..3)
// PORTS
//   clk                   in   1             system clock
//   rst                   in   1             asynchronous reset, active-low
//   wb_cyc_i              in   1             bus cycle
//   wb_stb_i              in   1             strobe
//   wb_we_i               in   1             1 = write
//   wb_sel_i              in   BYTE_COUNT    byte enables
//   wb_adr_i              in   ADDRESS_SIZE+2  byte address; bits [1:0] ignored
//   wb_data_i             in   DATA_WIDTH    write data
//   wb_ack_o              out  1             single-cycle ack
//   wb_data_o             out  DATA_WIDTH    read data, valid while wb_ack_o=1
//   rd_req_valid          in   1             secondary read request
//   rd_req_ready          out  1             request accepted when valid&ready
//   rd_req_address        in   ADDRESS_SIZE  secondary word address
//   rd_resp_valid         out  1             response strobe, one cycle per request
//   rd_resp_data          out  DATA_WIDTH    response data
//   sram_primarySelect, sram_primaryWriteEnable  out 1;  sram_primaryWriteMask out BYTE_COUNT
//   sram_primaryAddress out ADDRESS_SIZE; sram_primaryDataWrite out DATA_WIDTH
//   sram_primaryDataRead  in DATA_WIDTH
//   sram_secondarySelect out 1; sram_secondaryAddress out ADDRESS_SIZE
//   sram_secondaryDataRead in DATA_WIDTH
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, all outputs 0, read pipe cleared; rd_req_ready=0 while in reset.
//   Primary FSM IDLE / READ_WAIT / ACK:
//   - IDLE: request = cyc&stb. SRAM primary outputs driven combinationally from wb inputs only in
//     IDLE with request; else select=0, other SRAM outputs hold 0.
//     write -> select=1, we=1, mask=wb_sel_i, address=wb_adr_i[ADDRESS_SIZE+1:2] -> ACK.
//     read  -> select=1, we=0, mask=0 -> READ_WAIT, latency counter=READ_LATENCY.
//   - READ_WAIT: counter decrements; at 0 capture sram_primaryDataRead into wb_data_o -> ACK.
//     cyc falling in READ_WAIT aborts to IDLE, no ack, wb_data_o unchanged.
//   - ACK: wb_ack_o=1 for exactly this cycle (gated by cyc), then IDLE; stb seen in ACK not accepted.
//   - Latency: write ack 1 cycle after request; read ack READ_LATENCY+1 cycles after request.
//   - wb_sel_i=0 write: still acked, SRAM mask 0 (no bytes change).
//   Secondary read pipe:
//   - rd_req_ready=1 whenever out of reset; no backpressure; one request accepted per cycle.
//   - Accept -> sram_secondarySelect=1, address passed through same cycle.
//   - Valid bit shifts through READ_LATENCY-deep pipe; rd_resp_valid and registered rd_resp_data
//     appear exactly READ_LATENCY+1 cycles after acceptance, in request order, back-to-back ok.
//   - Consumer must take every response; none dropped or duplicated.
//   Simultaneous primary write and secondary read to same address: secondary returns old data.
//   Reset mid-operation: in-flight read discarded, no ack, no resp_valid after reset release.
// STRUCTURE
//   Package sram_port_pkg: state encoding localparams (IDLE/READ_WAIT/ACK), DATA_WIDTH function,
//   READ_LATENCY bounds check.
//   Sub-module sram_read_pipe: parameterised valid shift register + data capture, instantiated for
//   the secondary port; primary FSM stays in this module.
// TESTING (bench pairs controller with SRAM wrapper behavioural model, READ_LATENCY=1)
//   Write 0xDEADBEEF @0x010 sel=1111, read @0x010 -> write ack at +1 cycle, read ack at +2, data 0xDEADBEEF.
//   Write 0x000000AA sel=0001 over 0x11223344 -> readback 0x112233AA.
//   rd_req 8 consecutive cycles addr 0..7 -> rd_resp_valid 8 consecutive cycles, in-order data.
//   Primary write 0x5 @3 and secondary read @3 same cycle (old 0x9) -> resp 0x9, next read 0x5.
//   Drop cyc during READ_WAIT -> no ack; next write acks normally.
//   Assert rst mid read and mid rd pipe -> ack/resp_valid stay 0, outputs 0, recovers after release.

Source files
------------

// File: rtl/sram_port_pkg.sv
// Shared types and elaboration helpers for the Wishbone / SRAM port controller.
package sram_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_WAIT = 2'd1,
        ST_ACK       = 2'd2
    } state_e;

    localparam int unsigned MIN_READ_LATENCY = 1;
    localparam int unsigned MAX_READ_LATENCY = 3;
    localparam int unsigned LAT_CNT_W        = 2;

    function automatic int unsigned data_width(input int unsigned byte_count);
        return 8 * byte_count;
    endfunction

    function automatic bit read_latency_ok(input int unsigned lat);
        return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Tracks in-flight secondary reads and registers SRAM data once it is valid,
// so each response appears DEPTH+1 cycles after its request was accepted.
module sram_read_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DEPTH-1:0]      vld_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            vld_q[0] <= req_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            valid_q <= vld_q[DEPTH-1];
            // Last stage set means the SRAM read bus holds this request's word now.
            if (vld_q[DEPTH-1]) begin
                data_q <= rdata_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/wb_sram_port_controller.sv
// Wishbone classic slave on the SRAM primary RW port plus a non-blocking
// valid/ready read pipe on the secondary R port.
module wb_sram_port_controller
    import sram_port_pkg::*;
#(
    parameter int unsigned BYTE_COUNT   = 4,
    parameter int unsigned ADDRESS_SIZE = 9,
    parameter int unsigned READ_LATENCY = 1,
    localparam int unsigned DATA_WIDTH  = data_width(BYTE_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [BYTE_COUNT-1:0]   wb_sel_i,
    input  logic [ADDRESS_SIZE+1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    output logic                    wb_ack_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [ADDRESS_SIZE-1:0] rd_req_address,
    output logic                    rd_resp_valid,
    output logic [DATA_WIDTH-1:0]   rd_resp_data,
    output logic                    sram_primarySelect,
    output logic                    sram_primaryWriteEnable,
    output logic [BYTE_COUNT-1:0]   sram_primaryWriteMask,
    output logic [ADDRESS_SIZE-1:0] sram_primaryAddress,
    output logic [DATA_WIDTH-1:0]   sram_primaryDataWrite,
    input  logic [DATA_WIDTH-1:0]   sram_primaryDataRead,
    output logic                    sram_secondarySelect,
    output logic [ADDRESS_SIZE-1:0] sram_secondaryAddress,
    input  logic [DATA_WIDTH-1:0]   sram_secondaryDataRead
);

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("READ_LATENCY must be within 1..3");
    end

    state_e                state_q, state_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  wb_req;
    logic                  rd_accept;
    logic                  unused_adr_lsb;

    assign unused_adr_lsb = ^wb_adr_i[1:0];

    // Requests are masked while reset is held so the SRAM sees nothing.
    assign wb_req    = wb_cyc_i & wb_stb_i & rst;
    assign rd_accept = rd_req_valid & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d                 = state_q;
        cnt_d                   = cnt_q;
        rdata_d                 = rdata_q;
        sram_primarySelect      = 1'b0;
        sram_primaryWriteEnable = 1'b0;
        sram_primaryWriteMask   = '0;
        sram_primaryAddress     = '0;
        sram_primaryDataWrite   = '0;
        case (state_q)
            ST_IDLE: begin
                if (wb_req) begin
                    sram_primarySelect  = 1'b1;
                    sram_primaryAddress = wb_adr_i[ADDRESS_SIZE+1:2];
                    if (wb_we_i) begin
                        sram_primaryWriteEnable = 1'b1;
                        sram_primaryWriteMask   = wb_sel_i;
                        sram_primaryDataWrite   = wb_data_i;
                        state_d                 = ST_ACK;
                    end else begin
                        cnt_d   = LAT_CNT_W'(READ_LATENCY);
                        state_d = ST_READ_WAIT;
                    end
                end
            end
            ST_READ_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                    if (cnt_d == '0) begin
                        rdata_d = sram_primaryDataRead;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wb_ack_o  = (state_q == ST_ACK) & wb_cyc_i;
    assign wb_data_o = rdata_q;

    assign rd_req_ready          = rst;
    assign sram_secondarySelect  = rd_accept;
    assign sram_secondaryAddress = rd_accept ? rd_req_address : '0;

    sram_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (READ_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst),
        .req_i   (rd_accept),
        .rdata_i (sram_secondaryDataRead),
        .valid_o (rd_resp_valid),
        .data_o  (rd_resp_data)
    );

endmodule
